fsm_state_monitor: RTL
======================

// Module: fsm_state_monitor
// PURPOSE
//   Downstream observer for the 3-state sequencer's registered 4-bit state output
//   (IDLE -> S1 -> S2 -> IDLE).
//   - Detects every state change and reports one event per change: from-code, to-code,
//     and how many cycles the old state was held.
//   - Flags any transition outside the legal ring.
//   - Counts completed IDLE->S1->S2->IDLE loops.
//   - Feeds debug LEDs / logic-analyser taps; never drives the sequencer.
// PARAMETERS
//   DW        8     width of dwell counter / evt_dwell (saturating)
//   IDLE_CODE 4'd0  state code for IDLE
//   S1_CODE   4'd1  state code for S1
//   S2_CODE   4'd2  state code for S2
// PORTS
//   clk        in   1    system clock, all logic on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   state_in   in   4    sequencer state code (already registered upstream)
//   evt_vld    out  1    one-cycle pulse: state change reported on evt_* this cycle
//   evt_from   out  4    code of the state just left
//   evt_to     out  4    code of the state just entered
//   evt_dwell  out  DW   cycles the left state was held (saturated)
//   illegal    out  1    sticky: an illegal transition has been seen since reset
//   loop_cnt   out  8    completed S2->IDLE transitions, wraps 255->0
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - evt_vld=0, evt_from=0, evt_to=0, evt_dwell=0, illegal=0, loop_cnt=0.
//   - Internal cur_q=IDLE_CODE, dwell=0 (reset is not counted as an entry edge).
//   Every rising edge, when state_in != cur_q (change):
//   - evt_vld<=1, evt_from<=cur_q, evt_to<=state_in, evt_dwell<=dwell.
//   - cur_q<=state_in, dwell<=1.
//   Every rising edge, when state_in == cur_q:
//   - evt_vld<=0; evt_from, evt_to and evt_dwell hold their last values.
//   - dwell<=dwell+1, saturating at 2^DW-1 (no wrap).
//   Latency:
//   - Event outputs are registered, so evt_vld is high in the cycle after the edge
//     that first samples the new code.
//   - Changes on consecutive edges give back-to-back evt_vld pulses, each with
//     evt_dwell=1; no event is dropped or merged.
//   Legal transitions: IDLE->S1, S1->S2, S2->IDLE.
//   - Any other change sets illegal<=1 on the same edge as its event, e.g. IDLE->S2,
//     S1->IDLE, or any move to/from a code not in {IDLE,S1,S2}.
//   - illegal is cleared only by rst_n.
//   - The monitor keeps tracking after an illegal transition: cur_q follows state_in,
//     including unknown codes.
//   loop_cnt increments by 1 on the edge that records a legal S2->IDLE event.
//   Holding state_in at any value forever produces no events; dwell stays saturated.
//   Reset mid-operation: all outputs return to reset values immediately; any
//   in-flight event is discarded.
//   A non-IDLE first code after reset is a change from cur_q=IDLE_CODE:
//   - It is reported with evt_dwell = cycles since reset release.
//   - It is judged legal or illegal like any other transition.
// TESTING
//   1. Reset, then hold 0 x3, 1 x5, 2 x7, then 0.
//      -> events (0->1, dwell 3), (1->2, dwell 5), (2->0, dwell 7); loop_cnt=1; illegal=0.
//   2. Run the loop of test 1 ten times.
//      -> 30 evt_vld pulses, loop_cnt=10, no pulses while state_in is stable.
//   3. From IDLE, drive 2 then 4'hF.
//      -> events (0->2) and (2->F); illegal=1 after the first of them and stays 1.
//   4. DW=4, hold S1 for 20 cycles, then S2.
//      -> event (1->2) with evt_dwell=15 (saturated).
//   5. Toggle 0,1,0,1 on consecutive edges.
//      -> 3 consecutive evt_vld cycles, each with evt_dwell=1; illegal=1 (S1->IDLE).
//   6. Assert rst_n mid-S2 while evt_vld is high.
//      -> all outputs 0 immediately; the first event after release has evt_from=0.

Source files
------------

// File: rtl/fsm_state_monitor.sv
// Passive observer of the sequencer state code: reports each change as a registered event,
// flags transitions outside the IDLE->S1->S2->IDLE ring and counts completed loops.
module fsm_state_monitor #(
  parameter int unsigned DW        = 8,
  parameter logic [3:0]  IDLE_CODE = 4'd0,
  parameter logic [3:0]  S1_CODE   = 4'd1,
  parameter logic [3:0]  S2_CODE   = 4'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    state_in,
  output logic          evt_vld,
  output logic [3:0]    evt_from,
  output logic [3:0]    evt_to,
  output logic [DW-1:0] evt_dwell,
  output logic          illegal,
  output logic [7:0]    loop_cnt
);

  localparam logic [DW-1:0] DwellMax = '1;
  localparam logic [DW-1:0] DwellOne = DW'(1);

  logic [3:0]    cur_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          evt_vld_q;
  logic [3:0]    evt_from_q, evt_to_q;
  logic [DW-1:0] evt_dwell_q;
  logic          illegal_q;
  logic [7:0]    loop_cnt_q;

  logic change;
  logic legal;
  logic loop_done;

  always_comb begin
    change    = (state_in != cur_q);
    legal     = ((cur_q == IDLE_CODE) && (state_in == S1_CODE)) ||
                ((cur_q == S1_CODE)   && (state_in == S2_CODE)) ||
                ((cur_q == S2_CODE)   && (state_in == IDLE_CODE));
    loop_done = change && (cur_q == S2_CODE) && (state_in == IDLE_CODE);
    // Saturate rather than wrap so a long hold never reports a misleadingly short dwell.
    if (change) begin
      dwell_d = DwellOne;
    end else if (dwell_q == DwellMax) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DwellOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= IDLE_CODE;
      dwell_q     <= '0;
      evt_vld_q   <= 1'b0;
      evt_from_q  <= 4'd0;
      evt_to_q    <= 4'd0;
      evt_dwell_q <= '0;
      illegal_q   <= 1'b0;
      loop_cnt_q  <= 8'd0;
    end else begin
      cur_q     <= state_in;
      dwell_q   <= dwell_d;
      evt_vld_q <= change;
      if (change) begin
        evt_from_q  <= cur_q;
        evt_to_q    <= state_in;
        evt_dwell_q <= dwell_q;
        if (!legal) begin
          illegal_q <= 1'b1;
        end
      end
      if (loop_done) begin
        loop_cnt_q <= loop_cnt_q + 8'd1;
      end
    end
  end

  assign evt_vld   = evt_vld_q;
  assign evt_from  = evt_from_q;
  assign evt_to    = evt_to_q;
  assign evt_dwell = evt_dwell_q;
  assign illegal   = illegal_q;
  assign loop_cnt  = loop_cnt_q;

endmodule
